// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: address/word types, FSM
// states and the entry format carried from fetch to decode.
package fetch_stage_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] u32;

  localparam addr_t PCINIT_DEF = 64'h8000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2,
    MISAL   = 2'd3
  } fetch_state_t;

  typedef struct packed {
    addr_t pc;
    u32    raw_instr;
    logic  misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_buf.sv
// Two-entry queue between fetch and decode: an output register (head) plus a
// skid register that catches one word when decode stalls. Flush empties both.
module fetch_buf
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  fetch_entry_t out_q;
  fetch_entry_t skid_q;
  logic         out_v;
  logic         skid_v;
  logic         do_pop;

  assign do_pop = pop & out_v;
  assign full   = skid_v;
  assign empty  = ~out_v;
  // Head is zeroed when empty so no stale PC is ever visible downstream.
  assign head   = out_v ? out_q : '0;

  // Queue storage: skid drains into out on pop; a push fills the first free slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (do_pop) begin
      if (skid_v) begin
        out_q <= skid_q;
        if (push) skid_q <= push_entry;
        else      skid_v <= 1'b0;
      end else if (push) begin
        out_q <= push_entry;
      end else begin
        out_v <= 1'b0;
      end
    end else if (push) begin
      if (!out_v) begin
        out_q <= push_entry;
        out_v <= 1'b1;
      end else if (!skid_v) begin
        skid_q <= push_entry;
        skid_v <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues hold-until-ack bus requests,
// queues fetched words for decode and handles redirects / misaligned PCs.
//
// Handshakes: the bus request (ireq_valid/ireq_addr) is held stable from the
// first cycle ireq_valid=1 until the cycle iresp_data_ok=1, which completes
// it. Decode takes d_* in any cycle with d_valid=1 and d_ready=1; while
// d_valid=1 and d_ready=0 the d_* outputs do not change.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter addr_t PCINIT = PCINIT_DEF,
  parameter int    ILEN   = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [63:0]     ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [ILEN-1:0] iresp_data,
  input  logic            redirect_valid,
  input  logic [63:0]     redirect_pc,
  input  logic            d_ready,
  output logic            d_valid,
  output logic [63:0]     d_pc,
  output logic [ILEN-1:0] d_raw_instr,
  output logic            d_misalign
);

  fetch_state_t state, state_next;
  addr_t        pc, pc_next;
  addr_t        disc_addr, disc_next;
  logic         req_int;
  logic         pc_misal;
  logic         push;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic         buf_full;
  logic         buf_empty;

  assign pc_misal = (pc[1:0] != 2'b00);
  // A request is live in FETCH (aligned PC) and while draining a flushed one.
  assign req_int  = ((state == FETCH) && !pc_misal) || (state == DISCARD);

  assign ireq_valid = req_int & ~reset;
  assign ireq_addr  = !ireq_valid        ? '0        :
                      (state == DISCARD) ? disc_addr : pc;

  // State, PC and the address of a flushed-but-unacked request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= PCINIT;
      disc_addr <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      disc_addr <= disc_next;
    end
  end

  // Next-state, PC update and queue push; redirect overrides everything.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    disc_next  = disc_addr;
    push       = 1'b0;
    push_entry = '0;
    if (redirect_valid) begin
      pc_next = redirect_pc;
      if ((state == FETCH) && req_int && !iresp_data_ok) begin
        state_next = DISCARD;
        disc_next  = pc;
      end else if ((state == DISCARD) && !iresp_data_ok) begin
        state_next = DISCARD;
      end else begin
        state_next = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (pc_misal) begin
            if (!buf_full) begin
              push       = 1'b1;
              push_entry = '{pc: pc, raw_instr: '0, misalign: 1'b1};
              state_next = MISAL;
            end
          end else if (iresp_data_ok) begin
            push       = 1'b1;
            push_entry = '{pc: pc, raw_instr: iresp_data, misalign: 1'b0};
            pc_next    = pc + 64'd4;
            if (!buf_empty && !d_ready) state_next = HOLD;
          end
        end
        HOLD:    if (d_ready) state_next = FETCH;
        DISCARD: if (iresp_data_ok) state_next = FETCH;
        default: state_next = MISAL;
      endcase
    end
  end

  fetch_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (d_ready),
    .head       (head),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  assign d_valid     = ~buf_empty;
  assign d_pc        = head.pc;
  assign d_raw_instr = head.raw_instr;
  assign d_misalign  = head.misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: walks the fetch pipeline cycle by cycle
// through streaming, decode stall, redirects and a misaligned target.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        d_ready;
  logic        d_valid;
  logic [63:0] d_pc;
  logic [31:0] d_raw_instr;
  logic        d_misalign;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .d_ready        (d_ready),
    .d_valid        (d_valid),
    .d_pc           (d_pc),
    .d_raw_instr    (d_raw_instr),
    .d_misalign     (d_misalign)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ok, input logic [31:0] data, input logic rv,
                       input logic [63:0] rpc, input logic rdy);
    iresp_data_ok  = ok;
    iresp_data     = data;
    redirect_valid = rv;
    redirect_pc    = rpc;
    d_ready        = rdy;
  endtask

  task automatic check_d(input string tag, input logic v, input logic [63:0] pc,
                         input logic [31:0] ins, input logic mis);
    check({tag, ".d_valid"}, {63'd0, d_valid}, {63'd0, v});
    check({tag, ".d_pc"}, d_pc, pc);
    check({tag, ".d_raw"}, {32'd0, d_raw_instr}, {32'd0, ins});
    check({tag, ".d_mis"}, {63'd0, d_misalign}, {63'd0, mis});
  endtask

  task automatic check_req(input string tag, input logic v, input logic [63:0] addr);
    check({tag, ".ireq_valid"}, {63'd0, ireq_valid}, {63'd0, v});
    if (v) check({tag, ".ireq_addr"}, ireq_addr, addr);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    tick();
    tick();
    // reset values
    check_d("rst", 1'b0, 64'h0, 32'h0, 1'b0);
    check("rst.ireq_valid", {63'd0, ireq_valid}, 64'd0);
    check("rst.ireq_addr", ireq_addr, 64'h0);
    reset = 1'b0;
    #1;
    check_req("rel0", 1'b1, 64'h8000_0000);
    drive(1'b1, 32'h1111_0000, 1'b0, 64'h0, 1'b1);
    tick();
    check_d("pre", 1'b1, 64'h8000_0000, 32'h1111_0000, 1'b0);

    // 1. reset mid-run: asynchronous effect, then restart from PCINIT
    reset = 1'b1;
    #1;
    check("arst.ireq_valid", {63'd0, ireq_valid}, 64'd0);
    check("arst.d_valid", {63'd0, d_valid}, 64'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    #1;
    check_req("t1.c0", 1'b1, 64'h8000_0000);
    check("t1.c0.d_valid", {63'd0, d_valid}, 64'd0);
    drive(1'b1, 32'h0000_0011, 1'b0, 64'h0, 1'b1);
    tick();
    check_d("t1.c1", 1'b1, 64'h8000_0000, 32'h0000_0011, 1'b0);
    check_req("t1.c1", 1'b1, 64'h8000_0004);
    drive(1'b1, 32'h0000_0022, 1'b0, 64'h0, 1'b1);
    tick();
    check_d("t1.c2", 1'b1, 64'h8000_0004, 32'h0000_0022, 1'b0);
    check_req("t1.c2", 1'b1, 64'h8000_0008);
    drive(1'b1, 32'h0000_0033, 1'b0, 64'h0, 1'b1);
    tick();
    check_d("t1.c3", 1'b1, 64'h8000_0008, 32'h0000_0033, 1'b0);
    check_req("t1.c3", 1'b1, 64'h8000_000C);

    // 2. decode stalls 3 cycles: next word goes to skid, bus idles in HOLD
    drive(1'b1, 32'h0000_0044, 1'b0, 64'h0, 1'b0);
    tick();
    check_d("t2.s1", 1'b1, 64'h8000_0008, 32'h0000_0033, 1'b0);
    check_req("t2.s1", 1'b0, 64'h0);
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick();
    check_d("t2.s2", 1'b1, 64'h8000_0008, 32'h0000_0033, 1'b0);
    check_req("t2.s2", 1'b0, 64'h0);
    tick();
    check_d("t2.s3", 1'b1, 64'h8000_0008, 32'h0000_0033, 1'b0);
    check_req("t2.s3", 1'b0, 64'h0);
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    tick();
    check_d("t2.rel", 1'b1, 64'h8000_000C, 32'h0000_0044, 1'b0);
    check_req("t2.rel", 1'b1, 64'h8000_0010);

    // 3. redirect while request for _0010 is unacked -> DISCARD
    drive(1'b0, 32'h0, 1'b1, 64'h8000_0100, 1'b1);
    tick();
    check("t3.r.d_valid", {63'd0, d_valid}, 64'd0);
    check_req("t3.r", 1'b1, 64'h8000_0010);
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    tick();
    check("t3.w.d_valid", {63'd0, d_valid}, 64'd0);
    check_req("t3.w", 1'b1, 64'h8000_0010);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0, 1'b1);
    tick();
    check("t3.drop.d_valid", {63'd0, d_valid}, 64'd0);
    check_req("t3.drop", 1'b1, 64'h8000_0100);
    drive(1'b1, 32'h0000_0055, 1'b0, 64'h0, 1'b1);
    tick();
    check_d("t3.new", 1'b1, 64'h8000_0100, 32'h0000_0055, 1'b0);
    check_req("t3.new", 1'b1, 64'h8000_0104);

    // 4. redirect together with data_ok: word dropped, no DISCARD
    drive(1'b1, 32'h0000_0066, 1'b1, 64'h8000_0200, 1'b1);
    tick();
    check("t4.d_valid", {63'd0, d_valid}, 64'd0);
    check_req("t4", 1'b1, 64'h8000_0200);
    drive(1'b1, 32'h0000_0077, 1'b0, 64'h0, 1'b1);
    tick();
    check_d("t4.new", 1'b1, 64'h8000_0200, 32'h0000_0077, 1'b0);
    check_req("t4.new", 1'b1, 64'h8000_0204);

    // 6. fill out+skid, then redirect: nothing stale survives
    drive(1'b1, 32'h0000_0088, 1'b0, 64'h0, 1'b0);
    tick();
    check_d("t6.full", 1'b1, 64'h8000_0200, 32'h0000_0077, 1'b0);
    check_req("t6.full", 1'b0, 64'h0);
    drive(1'b0, 32'h0, 1'b1, 64'h8000_0300, 1'b0);
    tick();
    check_d("t6.flush", 1'b0, 64'h0, 32'h0, 1'b0);
    check_req("t6.flush", 1'b1, 64'h8000_0300);
    drive(1'b1, 32'h0000_0099, 1'b0, 64'h0, 1'b1);
    tick();
    check_d("t6.new", 1'b1, 64'h8000_0300, 32'h0000_0099, 1'b0);

    // 5. misaligned redirect target: single flagged entry, then idle
    drive(1'b1, 32'h0000_00AA, 1'b1, 64'h8000_0102, 1'b1);
    tick();
    check("t5.r.d_valid", {63'd0, d_valid}, 64'd0);
    check_req("t5.r", 1'b0, 64'h0);
    drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    tick();
    check_d("t5.ent", 1'b1, 64'h8000_0102, 32'h0, 1'b1);
    check_req("t5.ent", 1'b0, 64'h0);
    tick();
    check("t5.idle1.d_valid", {63'd0, d_valid}, 64'd0);
    check_req("t5.idle1", 1'b0, 64'h0);
    drive(1'b1, 32'h0000_00BB, 1'b0, 64'h0, 1'b1);
    tick();
    check("t5.idle2.d_valid", {63'd0, d_valid}, 64'd0);
    check_req("t5.idle2", 1'b0, 64'h0);
    drive(1'b0, 32'h0, 1'b1, 64'h8000_0400, 1'b1);
    tick();
    check_req("t5.exit", 1'b1, 64'h8000_0400);
    drive(1'b1, 32'h0000_00CC, 1'b0, 64'h0, 1'b1);
    tick();
    check_d("t5.run", 1'b1, 64'h8000_0400, 32'h0000_00CC, 1'b0);
    check_req("t5.run", 1'b1, 64'h8000_0404);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
